// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-enable divider, H/V counters, and a registered
// blanked-colour/sync output stage aligned one pixel behind X/Y.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       VIDEO_ON,
  output logic       PIX_EN,
  output logic       FRAME_START,
  input  logic [3:0] R_IN,
  input  logic [3:0] G_IN,
  input  logic [3:0] B_IN,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       HSYNC,
  output logic       VSYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [3:0]       r_q, r_d;
  logic [3:0]       g_q, g_d;
  logic [3:0]       b_q, b_d;

  logic pix_en_s, h_last_s, v_last_s, video_on_s, hsync_act_s, vsync_act_s;

  // Decode of the current raster position; PIX_EN is held low while in reset
  // so that CLK_DIV=1 still reports an idle enable under reset.
  always_comb begin
    pix_en_s    = RESET_N & (div_q == DIV_LAST);
    h_last_s    = (hcnt_q == H_LAST);
    v_last_s    = (vcnt_q == V_LAST);
    video_on_s  = (hcnt_q < H_ACT) & (vcnt_q < V_ACT);
    hsync_act_s = (hcnt_q >= HS_START) & (hcnt_q < HS_END);
    vsync_act_s = (vcnt_q >= VS_START) & (vcnt_q < VS_END);
  end

  // Next-state for divider, counters and the one-pixel-delayed output stage.
  always_comb begin
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (pix_en_s) begin
      div_d = {DIV_W{1'b0}};
      if (h_last_s) begin
        hcnt_d = 10'd0;
        if (v_last_s) begin
          vcnt_d = 10'd0;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
      end
      hsync_d = ~hsync_act_s;
      vsync_d = ~vsync_act_s;
      r_d     = video_on_s ? R_IN : 4'h0;
      g_d     = video_on_s ? G_IN : 4'h0;
      b_d     = video_on_s ? B_IN : 4'h0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // State registers with asynchronous reset to the idle/blank raster origin.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q   <= {DIV_W{1'b0}};
      hcnt_q  <= 10'd0;
      vcnt_q  <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
    end else begin
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign X           = hcnt_q;
  assign Y           = vcnt_q;
  assign VIDEO_ON    = video_on_s;
  assign PIX_EN      = pix_en_s;
  assign FRAME_START = pix_en_s & h_last_s & v_last_s;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule
